// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter: requester count,
// state encoding and the priority-pointer wrap helper.
package arb_pkg;

  localparam int ARB_N  = 8;
  localparam int ARB_IW = $clog2(ARB_N);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Pointer advance with explicit wrap so a non-power-of-two N would still work.
  function automatic logic [ARB_IW-1:0] next_ptr(input logic [ARB_IW-1:0] idx);
    if (idx == ARB_IW'(ARB_N - 1)) begin
      return '0;
    end
    return idx + ARB_IW'(1);
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational rotating-priority picker: returns the first set request at or
// after ptr (wrapping), as a one-hot vector plus its index.
module rr_pick_onehot
  import arb_pkg::*;
#(
  parameter  int N  = ARB_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);

  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [N-1:0]  rotated;
  logic [IW-1:0] rot_idx;
  logic [IW:0]   sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the
  // chosen index back into absolute requester numbering.
  always_comb begin
    rotated    = N'({req, req} >> ptr);
    rot_idx    = '0;
    pick_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        rot_idx    = IW'(i);
        pick_valid = 1'b1;
      end
    end
    sum = {1'b0, rot_idx} + {1'b0, ptr};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    pick_idx = sum[IW-1:0];
    pick     = '0;
    if (pick_valid) begin
      pick[pick_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_request_arbiter.sv
// 8-input round-robin arbiter with a bounded hold time; the registered grant is
// always one-hot or zero and feeds the downstream 8-to-3 encoder directly.
module rr_request_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = ARB_N,
  parameter  int MAX_HOLD = 16,
  localparam int CW       = $clog2(MAX_HOLD) + 1,
  localparam int IW       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         busy
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_t    state, state_next;
  logic [N-1:0]  grant_next;
  logic [IW-1:0] ptr, ptr_next;
  logic [IW-1:0] idx, idx_next;
  logic [CW-1:0] hold_cnt, hold_next;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  rr_pick_onehot #(.N(N)) u_pick (
    .req        (req),
    .ptr        (ptr),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      ptr      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      ptr      <= ptr_next;
      idx      <= idx_next;
      hold_cnt <= hold_next;
    end
  end

  // Release always passes through IDLE, which guarantees a zero cycle between
  // grants; other requests are only looked at from IDLE, so they stay pending.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    idx_next   = idx;
    hold_next  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_next = pick;
          idx_next   = pick_idx;
          hold_next  = '0;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[idx] || hold_cnt == HOLD_LAST) begin
          grant_next = '0;
          ptr_next   = next_ptr(idx);
          hold_next  = '0;
          state_next = ST_IDLE;
        end else begin
          hold_next = hold_cnt + CW'(1);
        end
      end
      default: begin
        grant_next = '0;
        hold_next  = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign grant_valid = |grant;
  assign busy        = (state == ST_GRANT);

endmodule
